// File: rtl/spram_rr_arbiter_pkg.sv
// spram_arb_pkg: shared state type and rotated first-set search for the RAM port arbiter
package spram_arb_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_t;

  function automatic int rot_first(input logic [15:0] v, input int ptr, input int n);
    int r;
    int i;
    r = -1;
    for (int k = 0; k < 16; k++) begin
      i = (ptr + k) % n;
      if (k < n && r < 0 && v[i[3:0]]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/spram_rr_arbiter_rr_pick.sv
// rr_pick: first valid requester at or above ptr with wrap, as one-hot grant and index
module rr_pick
  import spram_arb_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int p;
  // search the valid vector rotated by ptr; -1 means nobody is asking
  always_comb p = rot_first(16'(valid), int'(ptr), N);
  assign idx = IW'(p);
  assign gnt = p >= 0 ? N'(1) << idx : '0;
endmodule

// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: round-robin/locked-burst sharing of one write-first RAM port (SPRAM_ARB_FIXED_PRIO_EN selects fixed priority)
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 8,
  parameter int MAX_BURST = 4,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int IW = $clog2(N_REQ),
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ-1:0]          req_lock,
  input  logic [N_REQ*AW-1:0]       req_addr,
  input  logic [N_REQ*RAM_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [RAM_WIDTH-1:0]      rsp_data,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [AW-1:0]             ram_addr,
  output logic [RAM_WIDTH-1:0]      ram_din,
  input  logic [RAM_WIDTH-1:0]      ram_dout
);
`ifdef SPRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  arb_state_t       state;
  logic [IW-1:0]    rr_ptr, owner, pk_idx, gidx, nxt;
  logic [BW-1:0]    burst_cnt;
  logic [N_REQ-1:0] pk_gnt;
  logic             acc;
  rr_pick #(.N(N_REQ)) u_pick (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .gnt  (pk_gnt),
    .idx  (pk_idx)
  );
  // a locked owner excludes everyone else; in ARB the picker decides
  always_comb begin
    req_ready = state == LOCKED ? (req_valid[owner] ? N_REQ'(1) << owner : '0) : pk_gnt;
    gidx      = state == LOCKED ? owner : pk_idx;
    acc       = |req_ready;
    nxt       = gidx == IW'(N_REQ - 1) ? '0 : gidx + 1'b1;
    ram_en    = acc;
    ram_we    = acc & req_we[gidx];
    ram_addr  = req_addr[gidx*AW +: AW];
    ram_din   = req_wdata[gidx*RAM_WIDTH +: RAM_WIDTH];
    rsp_data  = ram_dout;
  end
  // arbitration state, burst bookkeeping and the one-cycle read-response tag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rsp_valid <= '0;
    end else begin
      rsp_valid <= acc && !req_we[gidx] ? req_ready : '0;
      if (state == ARB) begin
        if (acc) begin
          rr_ptr <= FIXED ? '0 : nxt;
          if (req_lock[gidx] && MAX_BURST > 1) begin
            state     <= LOCKED;
            owner     <= gidx;
            burst_cnt <= BW'(1);
          end
        end
      end else if (!acc) begin
        state     <= ARB;
        burst_cnt <= '0;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
        if (!req_lock[owner] || burst_cnt + 1'b1 == BW'(MAX_BURST)) begin
          state     <= ARB;
          burst_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb_spram_rr_arbiter: randomized and directed scoreboard bench for spram_rr_arbiter
module tb_spram_rr_arbiter;
  localparam int N = 4, W = 16, D = 8, MB = 4, AW = 3;
`ifdef SPRAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct {int g; logic [W-1:0] d; int due;} rsp_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_we = '0, req_lock = '0, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*W-1:0] req_wdata = '0;
  logic [W-1:0] rsp_data, ram_din, ram_dout;
  logic ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0] ram [D];
  logic [W-1:0] mmem [D];
  rsp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  bit m_lock = 0;
  int m_owner = 0, m_ptr = 0, m_cnt = 0;
  logic [N-1:0] last_rdy;

  spram_rr_arbiter #(.N_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(D), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write-first single-port RAM behind the arbiter
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) begin
        ram[ram_addr] <= ram_din;
        ram_dout <= ram_din;
      end else ram_dout <= ram[ram_addr];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v);
    if (m_lock) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // one cycle of stimulus: drive, check the combinational grant, advance the reference
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] we, input logic [N-1:0] lk,
                      input logic [N*AW-1:0] a, input logic [N*W-1:0] d, input logic r);
    int g;
    logic [AW-1:0] ga;
    rst = r; req_valid = v; req_we = we; req_lock = lk; req_addr = a; req_wdata = d;
    #1;
    g = pick(v);
    last_rdy = req_ready;
    chk("req_ready", 32'(req_ready), g < 0 ? 32'd0 : 32'd1 << g);
    chk("ram_en", 32'(ram_en), 32'(g >= 0));
    chk("ram_we", 32'(ram_we), 32'(g >= 0 && we[g]));
    if (g >= 0) begin
      ga = a[g*AW +: AW];
      chk("ram_addr", 32'(ram_addr), 32'(ga));
      if (we[g]) begin
        chk("ram_din", 32'(ram_din), 32'(d[g*W +: W]));
        mmem[ga] = d[g*W +: W];
      end else if (!r) q.push_back('{g, mmem[ga], cyc + 1});
    end
    if (r) begin
      m_lock = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_lock) begin
      if (!v[m_owner]) m_lock = 0;
      else begin
        m_cnt++;
        if (!lk[m_owner] || m_cnt == MB) m_lock = 0;
      end
    end else if (g >= 0) begin
      m_ptr = FIXED ? 0 : (g + 1) % N;
      if (lk[g] && MB > 1) begin m_lock = 1; m_owner = g; m_cnt = 1; end
    end
    @(negedge clk);
  endtask

  // response monitor: each cycle either the expected read tag/data or silence
  initial begin
    rsp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'd1 << e.g);
        chk("rsp_data", 32'(rsp_data), 32'(e.d));
      end else chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  end

  initial begin
    @(negedge clk);
    step('0, '0, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, '0, 1'b1);
    step('0, '0, '0, '0, '0, 1'b0);
    for (int k = 0; k < D; k++) step(4'b0001, 4'b0001, '0, 12'(k), 64'(k * 16'h1111), 1'b0);
    step('0, '0, '0, '0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(4'hF, '0, '0, 12'($urandom), '0, 1'b0);
      if (!FIXED) chk("rr_order", 32'(last_rdy), 32'd1 << (k % 4));
    end
    step(4'b0100, 4'b0100, '0, 12'h0C0, 64'h0000_BEEF_0000_0000, 1'b0);
    step(4'b0001, '0, '0, 12'h003, '0, 1'b0);
    chk("wf_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wf_rsp_data", 32'(rsp_data), 32'hBEEF);
    step('0, '0, '0, '0, '0, 1'b1);
    step(4'b0010, '0, 4'b0010, 12'($urandom), '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0111, '0, 4'b0010, 12'($urandom), '0, 1'b0);
      if (!FIXED) chk("burst_seq", 32'(last_rdy), k < 3 ? 32'h2 : 32'h4);
    end
    step('0, '0, '0, '0, '0, 1'b1);
    step(4'b1000, '0, 4'b1000, 12'($urandom), '0, 1'b0);
    step(4'b0001, '0, '0, 12'($urandom), '0, 1'b0);
    chk("drop_no_grant", 32'(last_rdy), 32'h0);
    step(4'b0011, '0, '0, 12'($urandom), '0, 1'b0);
    chk("drop_resume", 32'(last_rdy), 32'h1);
    step('0, '0, '0, '0, '0, 1'b1);
    step(4'b0010, '0, 4'b0010, 12'($urandom), '0, 1'b0);
    step(4'b0010, '0, 4'b0010, 12'($urandom), '0, 1'b1);
    chk("rst_cancel", 32'(rsp_valid), 32'h0);
    step(4'b1010, '0, '0, 12'($urandom), '0, 1'b0);
    chk("rst_first_grant", 32'(last_rdy), 32'h2);
    if (FIXED)
      for (int k = 0; k < 6; k++) begin
        step(4'b1001, 4'($urandom), '0, 12'($urandom), {$urandom, $urandom}, 1'b0);
        chk("fixed_prio", 32'(last_rdy), 32'h1);
      end
    for (int k = 0; k < 400; k++)
      step(4'($urandom), 4'($urandom), 4'($urandom & $urandom), 12'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 63) == 0);
    for (int k = 0; k < 3; k++) step('0, '0, '0, '0, '0, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
